// File: rtl/pinctrl_pkg.sv
// Shared definitions for the pin controllers and the sample collector:
// register offsets, command codes, page field, FIFO word layout.
package pinctrl_pkg;

    // Register page field of the 19-bit word address
    localparam int unsigned PAGE_LSB = 8;
    localparam int unsigned PAGE_MSB = 15;

    // Pin-controller register offsets within its page
    localparam logic [7:0] PC_REG_CMD        = 8'd5;
    localparam logic [7:0] PC_REG_SAMPLE     = 8'd7;
    localparam logic [7:0] PC_REG_SAMPLE_CNT = 8'd8;
    localparam logic [7:0] PC_REG_STATUS     = 8'd9;

    // Pin-controller local command codes
    typedef enum logic [3:0] {
        CmdNop      = 4'd0,
        CmdReset    = 4'd1,
        CmdStart    = 4'd2,
        CmdStop     = 4'd3,
        CmdClearCnt = 4'd4
    } pc_cmd_e;

    // Collector register offsets within its page
    localparam logic [7:0] COL_REG_CTRL       = 8'd0;
    localparam logic [7:0] COL_REG_PIN_MASK   = 8'd1;
    localparam logic [7:0] COL_REG_FIFO_DATA  = 8'd2;
    localparam logic [7:0] COL_REG_FIFO_COUNT = 8'd3;
    localparam logic [7:0] COL_REG_STATUS     = 8'd4;

    localparam int unsigned CTRL_RUN_BIT   = 0;
    localparam int unsigned CTRL_CLEAR_BIT = 1;

    // FIFO word layout: {pin[3:0], cnt[10:0], sample_bit}
    localparam int unsigned FW_PIN_LSB = 12;
    localparam int unsigned FW_CNT_LSB = 1;
    localparam int unsigned FW_CNT_W   = 11;
    localparam int unsigned FW_SMP_BIT = 0;

    // Scan FSM states
    typedef enum logic [2:0] {
        ScanIdle,
        ScanSel,
        ScanRdCnt,
        ScanRdSmp,
        ScanPush
    } scan_state_e;

    // Build a tagged FIFO word from pin index, new counter value and sample bit
    function automatic logic [15:0] fifo_word(input logic [3:0] pin, input logic [15:0] cnt,
                                              input logic smp);
        logic [15:0] w;
        w = '0;
        w[FW_PIN_LSB +: 4]        = pin;
        w[FW_CNT_LSB +: FW_CNT_W] = cnt[FW_CNT_W-1:0];
        w[FW_SMP_BIT]             = smp;
        return w;
    endfunction

    // Word address of a pin-controller register (pin i lives at page i)
    function automatic logic [18:0] pc_reg_addr(input logic [3:0] pin, input logic [7:0] off);
        return {3'b000, 4'h0, pin, off};
    endfunction

endpackage

// File: rtl/sample_fifo.sv
// Synchronous FIFO with push, pop and clear. A push while full only lands when
// a pop happens in the same cycle; a pop while empty is ignored. Clear wins.
module sample_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset
    always_ff @(posedge clk) begin
        if (do_push && !clear && !reset) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/sample_collector.sv
// Sample collector: round-robin scans enabled pin controllers, pushes a tagged
// word into a FIFO whenever a pin's sample counter changed, and exposes the
// FIFO plus control/status on its own host register page.
module sample_collector
    import pinctrl_pkg::*;
#(
    parameter int unsigned NUM_PINS   = 16,
    parameter int unsigned FIFO_DEPTH = 64,
    parameter logic [7:0]  POSITION   = 8'hF0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [18:0] addr,
    input  logic        data_wr,
    input  logic        data_rd,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    output logic [18:0] pc_addr,
    output logic        pc_rd,
    input  logic [15:0] pc_data
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // Host side
    logic                sel;
    logic [7:0]          offset;
    logic                wr_ctrl;
    logic                wr_mask;
    logic                clear;
    logic                rd_fifo;
    logic                pop_fire;
    logic                run_q;
    logic [15:0]         mask_q;
    logic                overflow_q;
    logic                pop_pending_q;
    logic                unused_addr;

    // FIFO
    logic                push_req;
    logic [15:0]         fifo_rdata;
    logic [CW-1:0]       fifo_count;
    logic                fifo_full;
    logic                fifo_empty;

    // Scan
    scan_state_e         state_q;
    logic [3:0]          pin_q;
    logic [15:0]         cnt_q;
    logic                smp_q;
    logic [18:0]         pc_addr_q;
    logic                pc_rd_q;
    logic [15:0]         last_cnt_q [NUM_PINS];
    logic [NUM_PINS-1:0] mask_eff;
    logic                next_found;
    logic [3:0]          next_pin;

    assign unused_addr = ^addr[18:16];
    assign sel      = enable && (addr[PAGE_MSB:PAGE_LSB] == POSITION);
    assign offset   = addr[7:0];
    assign wr_ctrl  = sel && data_wr && (offset == COL_REG_CTRL);
    assign wr_mask  = sel && data_wr && (offset == COL_REG_PIN_MASK);
    assign clear    = wr_ctrl && data_in[CTRL_CLEAR_BIT];
    assign rd_fifo  = sel && data_rd && (offset == COL_REG_FIFO_DATA);
    // Pop is deferred until the strobe drops so data_out holds for the whole read
    assign pop_fire = pop_pending_q && !data_rd;
    assign push_req = (state_q == ScanPush);
    assign mask_eff = mask_q[NUM_PINS-1:0];
    assign pc_addr  = pc_addr_q;
    assign pc_rd    = pc_rd_q && !reset;

    // Host control registers, pop arming and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q         <= 1'b0;
            mask_q        <= '0;
            pop_pending_q <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            if (wr_ctrl) run_q  <= data_in[CTRL_RUN_BIT];
            if (wr_mask) mask_q <= data_in;

            if (clear)                       pop_pending_q <= 1'b0;
            else if (pop_fire)               pop_pending_q <= 1'b0;
            else if (rd_fifo && !fifo_empty) pop_pending_q <= 1'b1;

            if (clear)                                   overflow_q <= 1'b0;
            else if (push_req && fifo_full && !pop_fire) overflow_q <= 1'b1;
        end
    end

    // Host read mux, combinational
    always_comb begin
        data_out = '0;
        if (sel) begin
            case (offset)
                COL_REG_CTRL:       data_out = {15'b0, run_q};
                COL_REG_PIN_MASK:   data_out = mask_q;
                COL_REG_FIFO_DATA:  data_out = fifo_empty ? 16'h0000 : fifo_rdata;
                COL_REG_FIFO_COUNT: data_out = 16'(fifo_count);
                COL_REG_STATUS:     data_out = {13'b0, overflow_q, fifo_full, fifo_empty};
                default:            data_out = '0;
            endcase
        end
    end

    // Next masked pin after the current one, wrapping; nearest candidate wins
    always_comb begin
        next_found = 1'b0;
        next_pin   = pin_q;
        for (int k = NUM_PINS; k >= 1; k--) begin
            int idx;
            idx = (int'(pin_q) + k) % NUM_PINS;
            if (mask_eff[idx]) begin
                next_found = 1'b1;
                next_pin   = 4'(idx);
            end
        end
    end

    // Scan FSM with registered bus outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ScanIdle;
            pin_q     <= 4'(NUM_PINS - 1);
            cnt_q     <= '0;
            smp_q     <= 1'b0;
            pc_addr_q <= '0;
            pc_rd_q   <= 1'b0;
            for (int i = 0; i < NUM_PINS; i++) last_cnt_q[i] <= '0;
        end else begin
            // last_cnt advances on PUSH whether or not the word fit
            if (clear) begin
                for (int i = 0; i < NUM_PINS; i++) last_cnt_q[i] <= '0;
            end else if (state_q == ScanPush) begin
                last_cnt_q[pin_q] <= cnt_q;
            end

            case (state_q)
                ScanIdle: begin
                    pc_rd_q <= 1'b0;
                    if (run_q && (|mask_eff)) state_q <= ScanSel;
                end
                ScanSel: begin
                    if (next_found) begin
                        pin_q     <= next_pin;
                        pc_addr_q <= pc_reg_addr(next_pin, PC_REG_SAMPLE_CNT);
                        pc_rd_q   <= 1'b1;
                        state_q   <= ScanRdCnt;
                    end else begin
                        state_q   <= ScanIdle;
                    end
                end
                ScanRdCnt: begin
                    if (pc_data != last_cnt_q[pin_q]) begin
                        cnt_q     <= pc_data;
                        pc_addr_q <= pc_reg_addr(pin_q, PC_REG_SAMPLE);
                        state_q   <= ScanRdSmp;
                    end else begin
                        pc_rd_q   <= 1'b0;
                        state_q   <= run_q ? ScanSel : ScanIdle;
                    end
                end
                ScanRdSmp: begin
                    smp_q   <= pc_data[0];
                    pc_rd_q <= 1'b0;
                    state_q <= ScanPush;
                end
                ScanPush: begin
                    state_q <= run_q ? ScanSel : ScanIdle;
                end
                default: begin
                    pc_rd_q <= 1'b0;
                    state_q <= ScanIdle;
                end
            endcase
        end
    end

    sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_req),
        .pop   (pop_fire),
        .clear (clear),
        .wdata (fifo_word(pin_q, cnt_q, smp_q)),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: doc/sample_collector.md
Name: sample_collector

Overview:
- Downstream consumer of the per-pin controllers' input-stream results.
- Round-robin scans each enabled pin controller over the internal read bus. Reads the pin's sample counter, and when the counter has changed, reads the sample register and pushes a tagged word into a FIFO.
- The host drains the FIFO through its own register page on the shared EBI-style bus. This replaces host polling of every pin.

Parameters:
- NUM_PINS, 16, number of pin controllers scanned (pin i sits at page i, addr[15:8]=i); max 16.
- FIFO_DEPTH, 64, FIFO entries; power of two.
- POSITION, 8'hF0, host register page of this block (addr[15:8]).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- enable  in  1  host bus chip enable
- addr  in  19  host bus word address
- data_wr  in  1  host write strobe
- data_rd  in  1  host read strobe
- data_in  in  16  host write data
- data_out  out  16  host read data; 0 when not selected
- pc_addr  out  19  scan address to pin controllers
- pc_rd  out  1  scan read strobe (drives pin controllers' data_rd)
- pc_data  in  16  OR of all pin controllers' data_out (combinational, same-cycle)

Behaviour:
- Host registers, BASE=POSITION<<8, selected when enable & addr[15:8]==POSITION:
  - +0 CTRL (R/W): bit0 run; bit1 clear (write-only, self-clearing).
  - +1 PIN_MASK (R/W): bit i enables pin i.
  - +2 FIFO_DATA (R): head word.
  - +3 FIFO_COUNT (R): entries, 0..FIFO_DEPTH.
  - +4 STATUS (R): bit0 empty, bit1 full, bit2 overflow (sticky).
- Reset values:
  - CTRL=0, PIN_MASK=0, FIFO empty, overflow=0.
  - All last_cnt[i]=0, state=IDLE.
  - pc_addr=0, pc_rd=0, data_out=0.
- Host read data is combinational.
- FIFO pop:
  - A FIFO_DATA read with data_rd high arms pop_pending.
  - The pop happens on the first cycle data_rd is low after that, so data_out stays stable for the whole strobe.
  - Reading FIFO_DATA while empty returns 16'h0000 and does not pop.
- FIFO word: {pin[3:0], cnt[10:0], sample_bit}, where cnt is the low 11 bits of the new sample counter and sample_bit is sample register bit 0.
- Scan FSM states: IDLE, SEL, RD_CNT, RD_SMP, PUSH.
  - IDLE: pc_rd=0. Go to SEL when run=1 and PIN_MASK!=0.
  - SEL: advance the pin index, wrapping at NUM_PINS-1, to the next masked pin; one cycle. Mask bits at or above NUM_PINS are ignored.
  - RD_CNT: pc_addr={3'b0,pin,8'd8}, pc_rd=1. Capture pc_data at the clock edge.
    - If captured != last_cnt[pin]: store it and go to RD_SMP.
    - Otherwise go to SEL, or to IDLE if run=0.
  - RD_SMP: pc_addr={3'b0,pin,8'd7}, pc_rd=1. Capture bit 0, go to PUSH.
  - PUSH: pc_rd=0. Write the word if not full; else drop it and set overflow. last_cnt is updated in both cases. Then go to SEL, or to IDLE if run=0.
- Timing:
  - Worst-case per-pin cost is 4 cycles; an unchanged pin costs 2.
  - Latency from a pin's counter change to the FIFO write is ≤ 4·NUM_PINS+4 cycles.
- Clearing run mid-scan completes the current pin's sequence, then goes to IDLE. The mask is sampled in SEL only.
- CTRL.clear empties the FIFO, clears overflow and zeroes all last_cnt.
  - It has priority over push and pop in the same cycle; a push in that cycle is discarded.
- Simultaneous push and pop when full: both take effect and count is unchanged. When empty, a pop is ignored and the push proceeds.
- Count wrap: last_cnt comparison is by inequality, so 16'hFFFF→16'h0000 is a change.
- Reset mid-operation returns every register to its reset value in one cycle; pc_rd is low in the same cycle.
- Host writes to this page never drive pc_rd.

Decomposition:
- Shared package pinctrl_pkg, used by both pin controllers and this block:
  - pin-controller register offsets (sample reg 7, sample count 8, status 9, local cmd 5);
  - command codes;
  - page field definition;
  - collector register offsets and FIFO word field positions.
- One sub-module, sample_fifo: synchronous FIFO with push, pop and clear, reporting count, full and empty; parameterized by DEPTH and WIDTH.

Test Plan:
- Mask=16'h0005, run=1. Pin 2 count goes 0→1 with sample 1 → exactly one FIFO word 16'h2003, FIFO_COUNT=1. Pin 0 is never read with pc_rd while unchanged beyond its RD_CNT.
- Mask=0, run=1 → FSM stays IDLE, pc_rd never asserted.
- Fill 64 entries, then one more change → count=64, STATUS=3'b110 (full and overflow set), 65th word absent. CTRL clear → count=0, STATUS=3'b001.
- Host read of FIFO_DATA with data_rd held 3 cycles → data_out stable all 3 cycles, one pop after release. Read when empty → 16'h0000, count stays 0.
- Pin 1 count 16'hFFFF→16'h0000 → word pushed with cnt field 0.
- Assert reset during RD_SMP → next cycle pc_rd=0, state IDLE, CTRL=0, FIFO empty.
